// File: rtl/dot_product_sequencer.sv
// Dot-product sequencer feeding a 3-stage pipelined 8x8 MAC: clear, stream N pairs, drain, capture.
// Optional abort input is compiled in when DOTSEQ_ABORT_EN is defined.
module dot_product_sequencer #(
    parameter int LEN_W     = 8,
    parameter int DRAIN_CYC = 3
) (
    input  logic             clk,
    input  logic             r,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    input  logic             in_valid,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    output logic             in_ready,
`ifdef DOTSEQ_ABORT_EN
    input  logic             abort,
`endif
    output logic             mac_clr,
    output logic [7:0]       mac_a,
    output logic [7:0]       mac_b,
    input  logic [15:0]      mac_acc,
    input  logic             mac_of,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [15:0]      res_acc,
    output logic             res_of
);

    localparam int DC_W = $clog2(DRAIN_CYC) + 1;
    localparam logic [DC_W-1:0] DRAIN_LAST = DC_W'(DRAIN_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_seq_next;
    state_t           w_next;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_remaining;
    logic [DC_W-1:0]  r_drain_cnt;
    logic             r_sticky;
    logic             r_mac_clr;
    logic             r_res_valid;
    logic [15:0]      r_res_acc;
    logic             r_res_of;
    logic             w_xfer;
    logic             w_drain_end;
    logic             w_abort;

`ifdef DOTSEQ_ABORT_EN
    logic w_active;
    assign w_active = (r_state == S_CLR) || (r_state == S_FEED) || (r_state == S_DRAIN);
    assign w_abort  = abort & w_active;
`else
    assign w_abort  = 1'b0;
`endif

    assign w_xfer      = (r_state == S_FEED) & in_valid;
    assign w_drain_end = (r_state == S_DRAIN) && (r_drain_cnt == DRAIN_LAST);

    assign busy      = (r_state != S_IDLE);
    assign in_ready  = (r_state == S_FEED);
    // Non-transfer cycles present zeros so the MAC accumulates nothing.
    assign mac_a     = w_xfer ? in_a : 8'd0;
    assign mac_b     = w_xfer ? in_b : 8'd0;
    assign mac_clr   = r_mac_clr;
    assign res_valid = r_res_valid;
    assign res_acc   = r_res_acc;
    assign res_of    = r_res_of;

    // Next-state decode; abort overrides every active-state transition.
    always_comb begin
        w_seq_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_seq_next = S_CLR;
                else       w_seq_next = S_IDLE;
            end
            S_CLR: begin
                if (r_len != {LEN_W{1'b0}}) w_seq_next = S_FEED;
                else                        w_seq_next = S_DRAIN;
            end
            S_FEED: begin
                if (w_xfer && (r_remaining == LEN_W'(1))) w_seq_next = S_DRAIN;
                else                                      w_seq_next = S_FEED;
            end
            S_DRAIN: begin
                if (w_drain_end) w_seq_next = S_DONE;
                else             w_seq_next = S_DRAIN;
            end
            S_DONE: begin
                if (r_res_valid && res_ready) w_seq_next = S_IDLE;
                else                          w_seq_next = S_DONE;
            end
            default: w_seq_next = S_IDLE;
        endcase
        w_next = w_abort ? S_IDLE : w_seq_next;
    end

    // State register.
    always_ff @(posedge clk or negedge r) begin
        if (!r) r_state <= S_IDLE;
        else    r_state <= w_next;
    end

    // Command latch, element countdown and drain timer.
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            r_len       <= {LEN_W{1'b0}};
            r_remaining <= {LEN_W{1'b0}};
            r_drain_cnt <= {DC_W{1'b0}};
        end else begin
            if ((r_state == S_IDLE) && start) r_len <= len;
            if (r_state == S_CLR)  r_remaining <= r_len;
            else if (w_xfer)       r_remaining <= r_remaining - LEN_W'(1);
            if (r_state == S_DRAIN) r_drain_cnt <= r_drain_cnt + DC_W'(1);
            else                    r_drain_cnt <= {DC_W{1'b0}};
        end
    end

    // MAC clear pulse and sticky overflow; the MAC drops of after the next clean add.
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            r_mac_clr <= 1'b0;
            r_sticky  <= 1'b0;
        end else begin
            r_mac_clr <= (w_next == S_CLR) | w_abort;
            if (r_state == S_CLR)
                r_sticky <= 1'b0;
            else if ((r_state == S_FEED) || (r_state == S_DRAIN))
                r_sticky <= r_sticky | mac_of;
        end
    end

    // Result capture at the end of the last drain cycle, released by the handshake.
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            r_res_valid <= 1'b0;
            r_res_acc   <= 16'd0;
            r_res_of    <= 1'b0;
        end else if (w_drain_end && !w_abort) begin
            r_res_valid <= 1'b1;
            r_res_acc   <= mac_acc;
            r_res_of    <= r_sticky | mac_of;
        end else if ((r_state == S_DONE) && res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Self-checking bench for dot_product_sequencer with a behavioural 3-stage saturating MAC.
module tb_dot_product_sequencer;

    localparam int LEN_W     = 8;
    localparam int DRAIN_CYC = 3;

    logic             clk = 1'b0;
    logic             r = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic             busy;
    logic             in_valid = 1'b0;
    logic [7:0]       in_a = 8'd0;
    logic [7:0]       in_b = 8'd0;
    logic             in_ready;
    logic             mac_clr;
    logic [7:0]       mac_a;
    logic [7:0]       mac_b;
    logic [15:0]      mac_acc;
    logic             mac_of;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [15:0]      res_acc;
    logic             res_of;
`ifdef DOTSEQ_ABORT_EN
    logic             abort = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dot_product_sequencer #(.LEN_W(LEN_W), .DRAIN_CYC(DRAIN_CYC)) dut (
        .clk(clk), .r(r), .start(start), .len(len), .busy(busy),
        .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_ready(in_ready),
`ifdef DOTSEQ_ABORT_EN
        .abort(abort),
`endif
        .mac_clr(mac_clr), .mac_a(mac_a), .mac_b(mac_b),
        .mac_acc(mac_acc), .mac_of(mac_of),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_acc(res_acc), .res_of(res_of)
    );

    // Behavioural MAC: product, pipe, saturating accumulate; of reflects the latest add only.
    logic [15:0] m_p1, m_p2;
    logic [16:0] m_sum;
    assign m_sum = {1'b0, mac_acc} + {1'b0, m_p2};
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            m_p1 <= 16'd0; m_p2 <= 16'd0; mac_acc <= 16'd0; mac_of <= 1'b0;
        end else if (mac_clr) begin
            m_p1 <= 16'd0; m_p2 <= 16'd0; mac_acc <= 16'd0; mac_of <= 1'b0;
        end else begin
            m_p1    <= {8'd0, mac_a} * {8'd0, mac_b};
            m_p2    <= m_p1;
            mac_acc <= m_sum[16] ? 16'hFFFF : m_sum[15:0];
            mac_of  <= m_sum[16];
        end
    end

    // Command description and observations of the last run.
    int q_a[$];
    int q_b[$];
    int q_v[$];
    int o_xfers, o_clr, o_rv, o_pre, o_ready_seen, o_gate_err;
    bit o_unstable, o_timeout, o_busy_after;
    logic [15:0] o_acc;
    logic        o_of;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: exact dot product, then clamp; overflow iff the true sum exceeds 16 bits.
    function automatic logic [16:0] ref_dot();
        longint s = 0;
        foreach (q_a[i]) s += longint'(q_a[i]) * longint'(q_b[i]);
        if (s > 65535) return {1'b1, 16'hFFFF};
        return {1'b0, 16'(s)};
    endfunction

    task automatic run_cmd(input int n, input int delay, input bit spam, input bit gaps);
        int idx = 0;
        bit seen_rv = 0;
        o_xfers = 0; o_clr = 0; o_rv = 0; o_pre = 0; o_ready_seen = 0; o_gate_err = 0;
        o_unstable = 0; o_timeout = 1; o_acc = 16'd0; o_of = 1'b0;
        start = 1'b1; len = LEN_W'(n); res_ready = (delay == 0);
        tick();
        start = 1'b0;
        for (int guard = 0; guard < 600; guard++) begin
            if (mac_clr) o_clr++;
            if (res_valid) begin
                if (!seen_rv) begin o_acc = res_acc; o_of = res_of; seen_rv = 1; end
                else if (res_acc !== o_acc || res_of !== o_of) o_unstable = 1;
                o_rv++;
                res_ready = (o_rv > delay);
            end else if (seen_rv) begin
                o_timeout = 0;
                break;
            end else if (busy) begin
                o_pre++;
            end
            if (in_ready) begin
                o_ready_seen++;
                if (q_v.size() > 0) in_valid = (q_v.pop_front() != 0);
                else if (gaps)      in_valid = ($urandom_range(0, 2) != 0);
                else                in_valid = 1'b1;
                in_a = (idx < n) ? 8'(q_a[idx]) : 8'($urandom);
                in_b = (idx < n) ? 8'(q_b[idx]) : 8'($urandom);
            end else begin
                in_valid = 1'($urandom_range(0, 1));
                in_a = 8'($urandom); in_b = 8'($urandom);
            end
            if (spam) start = (res_valid && res_ready) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            if (mac_a !== ((in_ready && in_valid) ? in_a : 8'd0) ||
                mac_b !== ((in_ready && in_valid) ? in_b : 8'd0)) o_gate_err++;
            if (in_ready && in_valid) begin o_xfers++; idx++; end
            tick();
        end
        start = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
        o_busy_after = busy;
    endtask

    task automatic test_reset();
        r = 1'b0; in_valid = 1'b1; in_a = 8'd5; in_b = 8'd6;
        #2;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        n_checks++; if (mac_clr !== 1'b0) begin n_fail++; $display("FAIL reset_mac_clr: got %b expected 0", mac_clr); end
        n_checks++; if (mac_a !== 8'd0) begin n_fail++; $display("FAIL reset_mac_a: got %h expected 00", mac_a); end
        n_checks++; if ({res_valid, res_of, res_acc} !== 18'd0) begin n_fail++; $display("FAIL reset_result: got v=%b of=%b acc=%h expected zeros", res_valid, res_of, res_acc); end
        in_valid = 1'b0;
        tick(); tick();
        r = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        q_a = {2, 4, 6}; q_b = {3, 5, 7}; q_v = {};
        run_cmd(3, 0, 0, 0);
        n_checks++; if (o_timeout) begin n_fail++; $display("FAIL basic_timeout: no result within budget"); end
        n_checks++; if (o_acc !== 16'h0044) begin n_fail++; $display("FAIL basic_acc: got %h expected 0044", o_acc); end
        n_checks++; if (o_of !== 1'b0) begin n_fail++; $display("FAIL basic_of: got %b expected 0", o_of); end
        n_checks++; if (o_clr != 1) begin n_fail++; $display("FAIL basic_clr_pulses: got %0d expected 1", o_clr); end
        n_checks++; if (o_rv != 1) begin n_fail++; $display("FAIL basic_rv_cycles: got %0d expected 1", o_rv); end
        n_checks++; if (o_pre != 1 + 3 + DRAIN_CYC) begin n_fail++; $display("FAIL basic_latency: got %0d expected %0d", o_pre, 4 + DRAIN_CYC); end
        n_checks++; if (o_busy_after !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after: got %b expected 0", o_busy_after); end
        n_checks++; if (o_gate_err != 0) begin n_fail++; $display("FAIL basic_mac_gating: %0d bad cycles expected 0", o_gate_err); end
    endtask

    task automatic test_saturation();
        logic [16:0] exp_r;
        q_a = {255, 255, 0}; q_b = {255, 255, 0}; q_v = {};
        exp_r = ref_dot();
        run_cmd(3, 0, 0, 0);
        n_checks++; if (o_acc !== exp_r[15:0]) begin n_fail++; $display("FAIL sat_acc: got %h expected %h", o_acc, exp_r[15:0]); end
        n_checks++; if (o_of !== exp_r[16]) begin n_fail++; $display("FAIL sat_sticky_of: got %b expected %b", o_of, exp_r[16]); end
    endtask

    task automatic test_len_zero();
        q_a = {}; q_b = {}; q_v = {};
        run_cmd(0, 0, 0, 0);
        n_checks++; if ({o_of, o_acc} !== 17'd0) begin n_fail++; $display("FAIL zero_result: got of=%b acc=%h expected 0/0000", o_of, o_acc); end
        n_checks++; if (o_ready_seen != 0) begin n_fail++; $display("FAIL zero_in_ready: asserted %0d cycles expected 0", o_ready_seen); end
        n_checks++; if (o_pre != 1 + DRAIN_CYC) begin n_fail++; $display("FAIL zero_latency: got %0d expected %0d", o_pre, 1 + DRAIN_CYC); end
    endtask

    task automatic test_gaps_backpressure();
        q_a = {1, 2, 3, 4}; q_b = {1, 2, 3, 4}; q_v = {1, 0, 0, 1, 1, 0, 1};
        run_cmd(4, 5, 1, 0);
        n_checks++; if (o_acc !== 16'd30) begin n_fail++; $display("FAIL gaps_acc: got %0d expected 30", o_acc); end
        n_checks++; if (o_xfers != 4) begin n_fail++; $display("FAIL gaps_xfers: got %0d expected 4", o_xfers); end
        n_checks++; if (o_rv != 6) begin n_fail++; $display("FAIL gaps_rv_cycles: got %0d expected 6", o_rv); end
        n_checks++; if (o_unstable) begin n_fail++; $display("FAIL gaps_hold: result changed while waiting, expected stable"); end
        n_checks++; if (o_busy_after !== 1'b0) begin n_fail++; $display("FAIL gaps_start_ignored: busy=%b expected 0", o_busy_after); end
        n_checks++; if (o_clr != 1) begin n_fail++; $display("FAIL gaps_clr_pulses: got %0d expected 1", o_clr); end
    endtask

    task automatic test_reset_mid();
        start = 1'b1; len = LEN_W'(5);
        tick();
        start = 1'b0;
        tick();
        in_valid = 1'b1; in_a = 8'd1; in_b = 8'd1;
        tick(); tick();
        in_valid = 1'b0;
        r = 1'b0;
        #1;
        n_checks++; if ({busy, in_ready, mac_clr, res_valid, res_of} !== 5'd0) begin n_fail++; $display("FAIL midrst_flags: got %b expected 00000", {busy, in_ready, mac_clr, res_valid, res_of}); end
        n_checks++; if (res_acc !== 16'd0 || mac_a !== 8'd0) begin n_fail++; $display("FAIL midrst_data: got acc=%h mac_a=%h expected 0", res_acc, mac_a); end
        tick();
        r = 1'b1;
        tick();
        q_a = {9}; q_b = {9}; q_v = {};
        run_cmd(1, 0, 0, 0);
        n_checks++; if (o_acc !== 16'd81 || o_of !== 1'b0) begin n_fail++; $display("FAIL midrst_recover: got acc=%0d of=%b expected 81/0", o_acc, o_of); end
    endtask

    task automatic test_random();
        logic [16:0] exp_r;
        int n, delay;
        bit big;
        for (int t = 0; t < 10; t++) begin
            n = $urandom_range(0, 10); delay = $urandom_range(0, 3); big = 1'($urandom_range(0, 1));
            q_a = {}; q_b = {}; q_v = {};
            for (int i = 0; i < n; i++) begin
                q_a.push_back(big ? $urandom_range(128, 255) : $urandom_range(0, 30));
                q_b.push_back(big ? $urandom_range(128, 255) : $urandom_range(0, 30));
            end
            exp_r = ref_dot();
            run_cmd(n, delay, 1'($urandom_range(0, 1)), 1);
            n_checks++; if ({o_of, o_acc} !== exp_r) begin n_fail++; $display("FAIL rand_result[%0d]: got of=%b acc=%h expected of=%b acc=%h", t, o_of, o_acc, exp_r[16], exp_r[15:0]); end
            n_checks++; if (o_xfers != n || o_clr != 1 || o_rv != delay + 1) begin n_fail++; $display("FAIL rand_protocol[%0d]: got xfers=%0d clr=%0d rv=%0d expected %0d/1/%0d", t, o_xfers, o_clr, o_rv, n, delay + 1); end
            n_checks++; if (o_gate_err != 0 || o_unstable || o_timeout || o_busy_after) begin n_fail++; $display("FAIL rand_misc[%0d]: gate=%0d unstable=%b timeout=%b busy=%b expected 0", t, o_gate_err, o_unstable, o_timeout, o_busy_after); end
        end
    endtask

`ifdef DOTSEQ_ABORT_EN
    task automatic test_abort();
        start = 1'b1; len = LEN_W'(4);
        tick();
        start = 1'b0;
        tick();
        in_valid = 1'b1; in_a = 8'd2; in_b = 8'd2;
        tick(); tick();
        in_valid = 1'b0; abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks++; if ({busy, mac_clr, res_valid} !== 3'b010) begin n_fail++; $display("FAIL abort_edge: got busy,clr,rv=%b expected 010", {busy, mac_clr, res_valid}); end
        tick();
        n_checks++; if ({busy, mac_clr, res_valid} !== 3'b000) begin n_fail++; $display("FAIL abort_after: got busy,clr,rv=%b expected 000", {busy, mac_clr, res_valid}); end
        q_a = {3}; q_b = {3}; q_v = {};
        run_cmd(1, 0, 0, 0);
        n_checks++; if (o_acc !== 16'd9 || o_of !== 1'b0) begin n_fail++; $display("FAIL abort_recover: got acc=%0d of=%b expected 9/0", o_acc, o_of); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_len_zero();
        test_gaps_backpressure();
        test_reset_mid();
        test_random();
`ifdef DOTSEQ_ABORT_EN
        test_abort();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
